// File: rtl/affine_loop_ctrl.sv
// Affine schedule controller for one unified-buffer port.
// Walks a 3-deep loop nest, firing at OFFSET + k*II cycles after flush.
module affine_loop_ctrl #(
    parameter int E0     = 1,
    parameter int E1     = 64,
    parameter int E2     = 64,
    parameter int OFFSET = 0,
    parameter int II     = 1,
    parameter int CW     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    output logic             valid,
    output logic [2:0][15:0] ctrl_vars,
    output logic             done
);

    localparam logic [15:0] E0M  = 16'(E0 - 1);
    localparam logic [15:0] E1M  = 16'(E1 - 1);
    localparam logic [15:0] E2M  = 16'(E2 - 1);
    localparam logic [CW-1:0] OFS = CW'(OFFSET);
    localparam logic [CW-1:0] IIV = CW'(II);

    logic          running;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_fire;
    logic [15:0]   d0;
    logic [15:0]   d1;
    logic [15:0]   d2;
    logic          done_r;

    logic fire;
    logic last;
    logic d1_wrap;
    logic d2_wrap;

    always_comb begin
        fire    = running & ~stall & (cnt == next_fire);
        d1_wrap = (d1 == E1M);
        d2_wrap = (d2 == E2M);
        last    = fire & d1_wrap & d2_wrap & (d0 == E0M);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            cnt       <= '0;
            next_fire <= '0;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            done_r    <= 1'b0;
        end else if (flush) begin
            running   <= 1'b1;
            cnt       <= '0;
            next_fire <= OFS;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            done_r    <= 1'b0;
        end else if (running && !stall) begin
            cnt <= cnt + 1'b1;
            if (fire) begin
                next_fire <= next_fire + IIV;
                // x is innermost, then y, then the root loop
                if (last) begin
                    d0      <= '0;
                    d1      <= '0;
                    d2      <= '0;
                    running <= 1'b0;
                    done_r  <= 1'b1;
                end else if (!d1_wrap) begin
                    d1 <= d1 + 16'd1;
                end else if (!d2_wrap) begin
                    d1 <= '0;
                    d2 <= d2 + 16'd1;
                end else begin
                    d1 <= '0;
                    d2 <= '0;
                    d0 <= d0 + 16'd1;
                end
            end
        end
    end

    assign valid     = fire;
    assign ctrl_vars = {d2, d1, d0};
    assign done      = done_r;

endmodule

// File: doc/affine_loop_ctrl.md
# affine_loop_ctrl

- Schedule controller that generates the `wen`/`ren` strobe and the `[2:0]` loop-index vector (`ctrl_vars`) driving one port of a unified buffer.
- Example: the write port of the `mult_stencil` buffer, driven by the `op_hcompute_mult_stencil` iteration space.
- Walks a 3-deep loop nest (d0 root, d1 x innermost, d2 y) on an affine cycle schedule: first firing at `OFFSET` cycles after flush, then one firing every `II` cycles.
- One instance sits between the global flush/stall distribution and each buffer port.

## Interface
Parameters:
- `E0`, default 1: extent of d0 (root loop).
- `E1`, default 64: extent of d1 (x, innermost).
- `E2`, default 64: extent of d2 (y).
- `OFFSET`, default 0: cycles from schedule start to the first firing.
- `II`, default 1: cycles between consecutive firings. Must be ≥1.
- `CW`, default 32: width of the cycle and next-fire counters.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `flush`, in, 1: synchronous schedule (re)start.
- `stall`, in, 1: freezes schedule time.
- `valid`, out, 1: firing strobe. Connects to the buffer's `_wen` or `_ren`.
- `ctrl_vars`, out, 16 × [2:0]: current indices. [0]=d0, [1]=d1, [2]=d2.
- `done`, out, 1: sticky; high once all `E0*E1*E2` firings have issued.

## Operation
State: `running`, `cnt` (CW), `next_fire` (CW), `d0`/`d1`/`d2` (16 each), `done_r`.

Reset (rst_n low, asynchronous):
- All state cleared to 0, `running`=0.
- Outputs: `valid`=0, `ctrl_vars`={0,0,0}, `done`=0.

Before the first flush:
- Idle. `valid` stays 0 indefinitely.

Flush (sampled high at an edge):
- `running`=1, `cnt`=0, `next_fire`=OFFSET, `d0`=`d1`=`d2`=0, `done_r`=0.
- Flush has priority over stall and over any firing in the same cycle.
- Flush mid-run abandons the run and restarts from index 0.

Firing condition:
- `fire = running & ~stall & (cnt == next_fire)`.
- `valid = fire`, combinational from registered state and `stall`.
- `ctrl_vars` = {`d2`,`d1`,`d0`} registered values, valid in the same cycle as `valid`.

Each non-stalled running cycle:
- `cnt` increments by 1.
- `stall` high: `cnt`, `next_fire` and the indices hold, and `valid`=0. A firing due in that cycle is deferred, not dropped.

On fire:
- `next_fire += II`.
- Index advance:
  - If `d1` < E1-1: `d1`++.
  - Else `d1`=0. Then if `d2` < E2-1: `d2`++.
  - Else `d2`=0 and `d0`++.
- On the firing with `d0`=E0-1, `d1`=E1-1, `d2`=E2-1: indices return to 0, `running`=0, `done_r`=1.

Counters:
- Never wrap within a legal run. Requirement: OFFSET + E0·E1·E2·II < 2^CW.

Output:
- `done = done_r`. It stays high until the next flush or reset.

## Timing
- Flush sampled at edge T:
  - Cycle T+1 has `cnt`=0.
  - With no stall, the first `valid` is at cycle T+1+OFFSET.
  - Firing k (0-based) is at T+1+OFFSET+k·II.
- Each stalled cycle delays all remaining firings by exactly 1 cycle.
- `done` rises in the cycle after the final firing.
- Firing k presents linear index k = d0·E1·E2 + d2·E1 + d1.
- Buffer address = d1 + 64·d2 (E1=64).
- rst_n asserted mid-run: outputs go to reset values immediately, without waiting for a clock edge. After release, the block is idle until the next flush.
- Flush and stall high in the same cycle: flush wins. Stall then applies from the next cycle.

## Test plan
- Reset: hold rst_n low, toggle `flush`/`stall` -> `valid`=0, `ctrl_vars`={0,0,0}, `done`=0 throughout. No flush after release -> `valid` never asserts.
- E0=1, E1=4, E2=2, OFFSET=3, II=1, flush at edge T:
  - `valid` high for cycles T+4..T+11.
  - `ctrl_vars[1]` = 0,1,2,3,0,1,2,3; `ctrl_vars[2]` = 0,0,0,0,1,1,1,1.
  - `done` rises at T+12.
- Same extents with II=3 -> 8 single-cycle pulses spaced exactly 3 cycles apart. Indices unchanged between pulses.
- Stall: hold `stall` 2 cycles exactly on the cycle firing 2 is due -> firing 2 (d1=2) issues 2 cycles late and all later firings shift by 2. Total firings = 8, no duplicates.
- Flush mid-run at firing 5 -> sequence restarts at {0,0,0} after OFFSET cycles. `done` stays 0 until the full 8 post-flush firings complete.
- Default parameters (64×64, II=1, OFFSET=0) -> 4096 consecutive `valid` cycles, last `ctrl_vars` = {63,63,0}, `done`=1 the following cycle. Driving a `mult_stencil` buffer write port with it fills addresses 0..4095 in order.
